// File: rtl/extmem_burst_reader_if.sv
// Bank-side port of extmem_burst_reader: tagged read requests out, tagged response beats in.
// The reader uses the master modport; a memory bank model or controller uses the slave modport.
interface extmem_burst_reader_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 128,
    parameter int TAG_WIDTH     = 2,
    parameter int BE_WIDTH      = 16
);
    logic                     req;
    logic                     ce;
    logic                     w;
    logic [ADDRESS_WIDTH-1:0] a;
    logic [TAG_WIDTH-1:0]     tag;
    logic [DATA_WIDTH-1:0]    d;
    logic [BE_WIDTH-1:0]      be;
    logic                     ready;
    logic                     valid;
    logic [DATA_WIDTH-1:0]    q;
    logic [TAG_WIDTH-1:0]     qtag;

    modport master (
        output req, ce, w, a, tag, d, be,
        input  ready, valid, q, qtag
    );

    modport slave (
        input  req, ce, w, a, tag, d, be,
        output ready, valid, q, qtag
    );
endinterface

// File: rtl/extmem_burst_reader.sv
// Credit-limited burst reader: issues tagged reads, buffers returned beats, streams them out.
// Define EXTMEM_RD_CHECKSUM_EN to add the XOR checksum port over delivered beats.
module extmem_burst_reader #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 128,
    parameter int TAG_WIDTH     = 2,
    parameter int BE_WIDTH      = 16,
    parameter int LEN_WIDTH     = 16,
    parameter int ADDR_STEP     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]     num_beats,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    extmem_burst_reader_if.master    bank,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    input  logic                     out_ready
`ifdef EXTMEM_RD_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]    checksum
`endif
);

    localparam int DEPTH = 1 << TAG_WIDTH;
    localparam int CW    = TAG_WIDTH + 1;
    localparam logic [CW:0]   CREDITS = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDRESS_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]     len;
    logic [LEN_WIDTH-1:0]     len_next;
    logic [LEN_WIDTH-1:0]     issued;
    logic [LEN_WIDTH-1:0]     issued_next;
    logic [LEN_WIDTH-1:0]     delivered;
    logic [TAG_WIDTH-1:0]     received;
    logic [CW-1:0]            outstanding;
    logic [CW-1:0]            outstanding_next;
    logic [CW-1:0]            fifo_count;
    logic [CW-1:0]            fifo_count_next;
    logic [CW:0]              credit_used;
    logic                     req_q;
    logic                     req_next;
    logic                     err_q;

    logic                     accept;
    logic                     issue;
    logic                     push;
    logic                     pop;
    logic                     last_pop;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [TAG_WIDTH-1:0]     wr_ptr;
    logic [TAG_WIDTH-1:0]     rd_ptr;

    assign accept    = (state == IDLE) && start;
    assign issue     = req_q && bank.ready;
    assign push      = bank.valid && (outstanding != '0);
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign last_pop  = pop && (state == RUN) && (delivered == len - LEN_WIDTH'(1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_beats == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_pop) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A response moves one credit from outstanding to the FIFO; only a stream pop returns it.
    always_comb begin
        len_next         = accept ? num_beats : len;
        issued_next      = accept ? '0 : issued + LEN_WIDTH'(issue);
        outstanding_next = accept ? '0 : outstanding + CW'(issue) - CW'(push);
        fifo_count_next  = fifo_count + CW'(push) - CW'(pop);
        credit_used      = {1'b0, outstanding_next} + {1'b0, fifo_count_next};
        req_next         = (state_next == RUN) && (issued_next < len_next)
                           && (credit_used < CREDITS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len         <= '0;
            issued      <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            req_q       <= 1'b0;
            addr        <= '0;
            received    <= '0;
            delivered   <= '0;
            err_q       <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            len         <= len_next;
            issued      <= issued_next;
            outstanding <= outstanding_next;
            fifo_count  <= fifo_count_next;
            req_q       <= req_next;

            if (accept) begin
                addr <= base_addr;
            end else if (issue) begin
                addr <= addr + ADDRESS_WIDTH'(ADDR_STEP);
            end

            if (accept) begin
                received <= '0;
            end else if (push) begin
                received <= received + TAG_WIDTH'(1);
            end

            if (accept) begin
                delivered <= '0;
            end else if (pop) begin
                delivered <= delivered + LEN_WIDTH'(1);
            end

            // Unsolicited beats and out-of-order tags both latch the sticky error.
            if (accept) begin
                err_q <= 1'b0;
            end else if (bank.valid && ((outstanding == '0) || (bank.qtag != received))) begin
                err_q <= 1'b1;
            end

            if (push) begin
                wr_ptr <= wr_ptr + TAG_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + TAG_WIDTH'(1);
            end
        end
    end

    // NOTE: the beat storage is not reset; out_data is masked while empty, so stale words never escape.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bank.q;
        end
    end

    assign out_data = out_valid ? mem[rd_ptr] : '0;

    assign bank.req = req_q;
    assign bank.ce  = req_q;
    assign bank.w   = 1'b0;
    assign bank.a   = addr;
    assign bank.tag = issued[TAG_WIDTH-1:0];
    assign bank.d   = '0;
    assign bank.be  = {BE_WIDTH{1'b1}};
    assign err      = err_q;

`ifdef EXTMEM_RD_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum ^ out_data;
        end
    end
`endif

    // The credit limit keeps outstanding + occupancy within DEPTH, so a full FIFO never sees a push.
    assert property (@(posedge clk) disable iff (rst) !(push && (fifo_count == FULL)));

endmodule
